clock_edit_ctrl: RTL and testbench

//  Front-panel edit sequencer for the digital clock. Turns debounced buttons into the

---
 rtl/clock_edit_ctrl.sv | 145 ++++++++++++++
 tb/tb_clock_edit_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/clock_edit_ctrl.sv
// Front-panel edit sequencer: turns debounced buttons into the view/field selection,
// inc/dec strobes with press-and-hold auto-repeat, an inactivity timeout and a seconds freeze.
module clock_edit_ctrl #(
  parameter int CNT_W         = 32,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int TIMEOUT_SEC   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_mode_p,
  input  logic       btn_set_p,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       mode_time,
  output logic [2:0] select_item,
  output logic       inc_p,
  output logic       dec_p,
  output logic       sec_run_en
);

  localparam int TO_W = $clog2(TIMEOUT_SEC + 1);
  localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT_SEC);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_SEC - 1);

  typedef enum logic [2:0] {
    RUN_TIME, RUN_DATE, E_HOUR, E_MIN, E_SEC, E_DAY, E_MONTH, E_YEAR
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] rpt_cnt, rpt_nxt;
  logic [TO_W-1:0]  to_cnt, to_nxt;
  logic             prev_up, prev_dn, blocked, blocked_nxt;
  logic             mode_nxt, sre_nxt, inc_nxt, dec_nxt;
  logic [2:0]       sel_nxt;

  logic is_edit, activity, to_hit, changing;
  logic up_only, dn_only, up_edge, dn_edge, live;

  assign is_edit  = (state != RUN_TIME) && (state != RUN_DATE);
  assign activity = btn_mode_p | btn_set_p | btn_up | btn_down;
  assign to_hit   = is_edit && !activity && tick_1hz && (to_cnt == TO_LAST);
  assign changing = (state_nxt != state);
  assign up_only  = btn_up & ~btn_down;
  assign dn_only  = btn_down & ~btn_up;
  assign up_edge  = up_only & ~prev_up;
  assign dn_edge  = dn_only & ~prev_dn;
  // A button still held from before a field change stays inert until fully released.
  assign live     = is_edit && !changing && !blocked;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN_TIME;
      mode_time   <= 1'b0;
      select_item <= 3'b000;
      sec_run_en  <= 1'b1;
      inc_p       <= 1'b0;
      dec_p       <= 1'b0;
      rpt_cnt     <= '0;
      to_cnt      <= '0;
      prev_up     <= 1'b0;
      prev_dn     <= 1'b0;
      blocked     <= 1'b0;
    end else begin
      state       <= state_nxt;
      mode_time   <= mode_nxt;
      select_item <= sel_nxt;
      sec_run_en  <= sre_nxt;
      inc_p       <= inc_nxt;
      dec_p       <= dec_nxt;
      rpt_cnt     <= rpt_nxt;
      to_cnt      <= to_nxt;
      prev_up     <= up_only;
      prev_dn     <= dn_only;
      blocked     <= blocked_nxt;
    end
  end

  // Set takes priority over mode and over a coincident timeout.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN_TIME: if (btn_set_p) state_nxt = E_HOUR;  else if (btn_mode_p) state_nxt = RUN_DATE;
      RUN_DATE: if (btn_set_p) state_nxt = E_DAY;   else if (btn_mode_p) state_nxt = RUN_TIME;
      E_HOUR:   if (btn_set_p) state_nxt = E_MIN;   else if (to_hit) state_nxt = RUN_TIME;
      E_MIN:    if (btn_set_p) state_nxt = E_SEC;   else if (to_hit) state_nxt = RUN_TIME;
      E_SEC:    if (btn_set_p || to_hit) state_nxt = RUN_TIME;
      E_DAY:    if (btn_set_p) state_nxt = E_MONTH; else if (to_hit) state_nxt = RUN_DATE;
      E_MONTH:  if (btn_set_p) state_nxt = E_YEAR;  else if (to_hit) state_nxt = RUN_DATE;
      E_YEAR:   if (btn_set_p || to_hit) state_nxt = RUN_DATE;
      default:  state_nxt = RUN_TIME;
    endcase
  end

  always_comb begin
    mode_nxt = 1'b0;
    sel_nxt  = 3'b000;
    unique case (state_nxt)
      RUN_DATE: mode_nxt = 1'b1;
      E_HOUR:   sel_nxt  = 3'b011;
      E_MIN:    sel_nxt  = 3'b010;
      E_SEC:    sel_nxt  = 3'b001;
      E_DAY:    begin mode_nxt = 1'b1; sel_nxt = 3'b100; end
      E_MONTH:  begin mode_nxt = 1'b1; sel_nxt = 3'b101; end
      E_YEAR:   begin mode_nxt = 1'b1; sel_nxt = 3'b110; end
      default:  ;
    endcase
    sre_nxt = (state_nxt != E_SEC);
  end

  // Repeat counter counts down to the next pulse and reloads on every pulse.
  always_comb begin
    inc_nxt     = 1'b0;
    dec_nxt     = 1'b0;
    rpt_nxt     = '0;
    blocked_nxt = (blocked | changing) & (btn_up | btn_down);
    if (live) begin
      if (up_edge || dn_edge) begin
        inc_nxt = up_edge;
        dec_nxt = dn_edge;
        rpt_nxt = RPT_FIRST;
      end else if (up_only || dn_only) begin
        if (rpt_cnt == '0) begin
          inc_nxt = up_only;
          dec_nxt = dn_only;
          rpt_nxt = RPT_NEXT;
        end else begin
          rpt_nxt = rpt_cnt - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    to_nxt = to_cnt;
    if (!is_edit || changing || activity)
      to_nxt = '0;
    else if (tick_1hz && to_cnt != TO_MAX)
      to_nxt = to_cnt + TO_W'(1);
  end

endmodule

// File: tb/tb_clock_edit_ctrl.sv
// Scoreboard bench for clock_edit_ctrl: each driven cycle pushes the output vector expected
// one clock later, which is popped and compared at the following falling edge.
module tb_clock_edit_ctrl;

  typedef logic [6:0] ovec_t;  // {mode_time, select_item, inc_p, dec_p, sec_run_en}

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0, btn_mode_p = 1'b0, btn_set_p = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0;
  logic       mode_time, inc_p, dec_p, sec_run_en;
  logic [2:0] select_item;

  ovec_t exp_q[$];
  string tag_q[$];
  int    n_chk = 0;
  int    n_pass = 0;

  always #5 clk = ~clk;

  clock_edit_ctrl #(
    .CNT_W(32), .REPEAT_DELAY(4), .REPEAT_PERIOD(2), .TIMEOUT_SEC(3)
  ) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_mode_p(btn_mode_p),
    .btn_set_p(btn_set_p), .btn_up(btn_up), .btn_down(btn_down),
    .mode_time(mode_time), .select_item(select_item), .inc_p(inc_p),
    .dec_p(dec_p), .sec_run_en(sec_run_en)
  );

  task automatic check_eq(input string tag, input ovec_t got, input ovec_t exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  function automatic ovec_t ov(input bit m, input bit [2:0] s);
    return {m, s, 2'b00, (s != 3'b001)};
  endfunction

  task automatic compare_pending();
    if (exp_q.size() > 0)
      check_eq(tag_q.pop_front(),
               {mode_time, select_item, inc_p, dec_p, sec_run_en}, exp_q.pop_front());
  endtask

  // Drives one cycle of inputs; e is the output vector required after the next rising edge.
  task automatic step(input string tag, input bit r, input bit m, input bit s,
                      input bit u, input bit d, input bit t, input ovec_t e);
    @(negedge clk);
    compare_pending();
    rst = r; btn_mode_p = m; btn_set_p = s; btn_up = u; btn_down = d; tick_1hz = t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  localparam ovec_t INC = 7'b0000100;
  localparam ovec_t DEC = 7'b0000010;

  ovec_t RT, RD, HR, MN, SC, DY, MO, YR;

  initial begin
    RT = ov(0, 3'b000); RD = ov(1, 3'b000);
    HR = ov(0, 3'b011); MN = ov(0, 3'b010); SC = ov(0, 3'b001);
    DY = ov(1, 3'b100); MO = ov(1, 3'b101); YR = ov(1, 3'b110);

    step("reset",      1, 0, 0, 0, 0, 0, RT);
    step("reset_hold", 1, 0, 0, 0, 0, 0, RT);
    step("idle",       0, 0, 0, 0, 0, 0, RT);

    // Time field walk
    step("set_hour",   0, 0, 1, 0, 0, 0, HR);
    step("set_min",    0, 0, 1, 0, 0, 0, MN);
    step("set_sec",    0, 0, 1, 0, 0, 0, SC);
    step("set_run",    0, 0, 1, 0, 0, 0, RT);

    // Date field walk
    step("mode_date",  0, 1, 0, 0, 0, 0, RD);
    step("set_day",    0, 0, 1, 0, 0, 0, DY);
    step("mode_ign",   0, 1, 0, 0, 0, 0, DY);
    step("set_month",  0, 0, 1, 0, 0, 0, MO);
    step("set_year",   0, 0, 1, 0, 0, 0, YR);
    step("set_rundate",0, 0, 1, 0, 0, 0, RD);
    step("mode_time",  0, 1, 0, 0, 0, 0, RT);

    // Set and mode together: set wins
    step("set_mode_win", 0, 1, 1, 0, 0, 0, HR);

    // Auto-repeat: pulses on output cycles 1,5,7,9,11
    for (int k = 0; k < 12; k++)
      step("hold_up", 0, 0, 0, 1, 0, 0, (k inside {0, 4, 6, 8, 10}) ? (HR | INC) : HR);
    step("release_up", 0, 0, 0, 0, 0, 0, HR);
    step("dn_edge",    0, 0, 0, 0, 1, 0, HR | DEC);
    step("dn_held",    0, 0, 0, 0, 1, 0, HR);
    step("dn_release", 0, 0, 0, 0, 0, 0, HR);

    // Button held across a set does not act on the new field
    step("up_hour",    0, 0, 0, 1, 0, 0, HR | INC);
    step("up_set",     0, 0, 1, 1, 0, 0, MN);
    for (int k = 0; k < 5; k++)
      step("up_blocked", 0, 0, 0, 1, 0, 0, MN);
    step("up_rel",     0, 0, 0, 0, 0, 0, MN);
    step("up_repress", 0, 0, 0, 1, 0, 0, MN | INC);
    step("up_rel2",    0, 0, 0, 0, 0, 0, MN);

    // Timeout from E_MIN after three ticks
    step("tick1",      0, 0, 0, 0, 0, 1, MN);
    step("gap",        0, 0, 0, 0, 0, 0, MN);
    step("tick2",      0, 0, 0, 0, 0, 1, MN);
    step("tick3_exit", 0, 0, 0, 0, 0, 1, RT);

    // Up ignored in RUN_TIME, and still blocked after entering edit
    step("up_run",     0, 0, 0, 1, 0, 0, RT);
    step("up_run_set", 0, 0, 1, 1, 0, 0, HR);
    step("up_run_blk", 0, 0, 0, 1, 0, 0, HR);
    step("up_run_rel", 0, 0, 0, 0, 0, 0, HR);
    step("set_min2",   0, 0, 1, 0, 0, 0, MN);

    // Button on the terminal tick keeps the edit, and restarts the count
    step("tk1",        0, 0, 0, 0, 0, 1, MN);
    step("tk2",        0, 0, 0, 0, 0, 1, MN);
    step("tk3_button", 0, 0, 0, 1, 0, 1, MN | INC);
    step("tk_rel",     0, 0, 0, 0, 0, 0, MN);
    step("tk4",        0, 0, 0, 0, 0, 1, MN);
    step("tk5",        0, 0, 0, 0, 0, 1, MN);
    step("tk6_exit",   0, 0, 0, 0, 0, 1, RT);

    // Date timeout returns to RUN_DATE
    step("mode_d2",    0, 1, 0, 0, 0, 0, RD);
    step("set_d2",     0, 0, 1, 0, 0, 0, DY);
    step("set_m2",     0, 0, 1, 0, 0, 0, MO);
    step("set_y2",     0, 0, 1, 0, 0, 0, YR);
    step("yt1",        0, 0, 0, 0, 0, 1, YR);
    step("yt2",        0, 0, 0, 0, 0, 1, YR);
    step("yt3_exit",   0, 0, 0, 0, 0, 1, RD);

    // Both buttons high: no pulses; dropping one is a fresh press
    step("set_day3",   0, 0, 1, 0, 0, 0, DY);
    for (int k = 0; k < 10; k++)
      step("both_high", 0, 0, 0, 1, 1, 0, DY);
    step("drop_down",  0, 0, 0, 1, 0, 0, DY | INC);
    step("up_held_d",  0, 0, 0, 1, 0, 0, DY);

    // Reset mid-edit
    step("rst_edit",   1, 0, 0, 1, 0, 0, RT);
    step("post_rst",   0, 0, 0, 0, 0, 0, RT);
    step("post_rst2",  0, 0, 0, 0, 0, 0, RT);

    @(negedge clk);
    compare_pending();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
